// File: rtl/hpu_cmd_tracker.sv
//==============================================================================
// hpu_cmd_tracker : per-HPU command-ID allocator, request stamper and
//                   completion store with wait/retire interface.
// Revision 1.0
//==============================================================================
`default_nettype none

package hpu_cmd_pkg;
  localparam int NUM_HPU_CMDS = 4;

  typedef struct packed {
    logic [7:0] cluster_id;
    logic [3:0] core_id;
    logic [3:0] local_cmd_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [3:0]    cmd_type;
    logic [31:0]   addr;
    logic [31:0]   length;
  } pspin_cmd_req_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [511:0]  imm_data;
  } pspin_cmd_resp_t;
endpackage

module hpu_cmd_tracker
  import hpu_cmd_pkg::*;
#(
  parameter int NUM_HPU_CMDS = hpu_cmd_pkg::NUM_HPU_CMDS,
  parameter int CLUSTER_ID   = 0,
  parameter int CORE_ID      = 0,
  localparam int IDW         = $clog2(NUM_HPU_CMDS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  pspin_cmd_req_t  issue_req_i,
  output logic [IDW-1:0]  issue_id_o,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output pspin_cmd_req_t  cmd_req_o,
  input  logic            resp_valid_i,
  input  pspin_cmd_resp_t resp_i,
  input  logic            wait_valid_i,
  input  logic [IDW-1:0]  wait_id_i,
  output logic            wait_ready_o,
  output logic [511:0]    wait_data_o,
  output logic [IDW:0]    inflight_o,
  output logic            err_o
);

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_ISSUED = 2'd1,
    SLOT_DONE   = 2'd2
  } slot_state_e;

  slot_state_e    state_q [NUM_HPU_CMDS];
  slot_state_e    state_d [NUM_HPU_CMDS];
  logic [511:0]   imm_q   [NUM_HPU_CMDS];
  logic [IDW:0]   inflight_q, inflight_d;
  logic           cmd_valid_q, cmd_valid_d;
  pspin_cmd_req_t cmd_req_q, cmd_req_d;
  logic           err_q, err_d;

  logic           any_free;
  logic [IDW-1:0] alloc_id;
  logic           issue_fire;
  logic [IDW-1:0] resp_slot;
  logic           resp_ok;
  logic           retire;
  pspin_cmd_req_t stamped_req;

  // Scan downwards so the lowest-index free slot wins.
  always_comb begin
    any_free = 1'b0;
    alloc_id = '0;
    for (int i = NUM_HPU_CMDS - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        any_free = 1'b1;
        alloc_id = IDW'(i);
      end
    end
  end

  assign issue_ready_o = any_free & (~cmd_valid_q | cmd_ready_i);
  assign issue_id_o    = alloc_id;
  assign issue_fire    = issue_valid_i & issue_ready_o;

  assign resp_slot = resp_i.cmd_id.local_cmd_id[IDW-1:0];
  assign resp_ok   = resp_valid_i
                   & (resp_i.cmd_id.cluster_id == 8'(CLUSTER_ID))
                   & (resp_i.cmd_id.core_id == 4'(CORE_ID))
                   & (int'(resp_i.cmd_id.local_cmd_id) < NUM_HPU_CMDS)
                   & (state_q[resp_slot] == SLOT_ISSUED);

  assign wait_ready_o = (state_q[wait_id_i] != SLOT_ISSUED);
  assign wait_data_o  = (state_q[wait_id_i] == SLOT_DONE) ? imm_q[wait_id_i] : '0;
  assign retire       = wait_valid_i & (state_q[wait_id_i] == SLOT_DONE);

  always_comb begin
    stamped_req                     = issue_req_i;
    stamped_req.cmd_id.cluster_id   = 8'(CLUSTER_ID);
    stamped_req.cmd_id.core_id      = 4'(CORE_ID);
    stamped_req.cmd_id.local_cmd_id = 4'(alloc_id);
  end

  // Issue, response and retire never collide on one slot: each acts only
  // on a slot in a distinct registered state.
  always_comb begin
    for (int i = 0; i < NUM_HPU_CMDS; i++) state_d[i] = state_q[i];
    inflight_d  = inflight_q;
    cmd_valid_d = cmd_valid_q;
    cmd_req_d   = cmd_req_q;
    err_d       = resp_valid_i & ~resp_ok;

    if (retire)     state_d[wait_id_i] = SLOT_FREE;
    if (resp_ok)    state_d[resp_slot] = SLOT_DONE;
    if (issue_fire) state_d[alloc_id]  = SLOT_ISSUED;

    if (issue_fire & ~retire)      inflight_d = inflight_q + 1'b1;
    else if (~issue_fire & retire) inflight_d = inflight_q - 1'b1;

    if (issue_fire) begin
      cmd_valid_d = 1'b1;
      cmd_req_d   = stamped_req;
    end else if (cmd_ready_i) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_HPU_CMDS; i++) begin
        state_q[i] <= SLOT_FREE;
        imm_q[i]   <= '0;
      end
      inflight_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_req_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_HPU_CMDS; i++) state_q[i] <= state_d[i];
      if (resp_ok) imm_q[resp_slot] <= resp_i.imm_data;
      inflight_q  <= inflight_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_req_q   <= cmd_req_d;
      err_q       <= err_d;
    end
  end

  assign inflight_o  = inflight_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_req_o   = cmd_req_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hpu_cmd_tracker.sv
//==============================================================================
// tb_hpu_cmd_tracker : directed bench for hpu_cmd_tracker (N=4, cluster 1, core 2).
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_hpu_cmd_tracker;
  import hpu_cmd_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  pspin_cmd_req_t  issue_req_i;
  logic [1:0]      issue_id_o;
  logic            cmd_valid_o;
  logic            cmd_ready_i;
  pspin_cmd_req_t  cmd_req_o;
  logic            resp_valid_i;
  pspin_cmd_resp_t resp_i;
  logic            wait_valid_i;
  logic [1:0]      wait_id_i;
  logic            wait_ready_o;
  logic [511:0]    wait_data_o;
  logic [2:0]      inflight_o;
  logic            err_o;

  int errors = 0;
  int checks = 0;

  hpu_cmd_tracker #(.NUM_HPU_CMDS(4), .CLUSTER_ID(1), .CORE_ID(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_req_i(issue_req_i), .issue_id_o(issue_id_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_req_o(cmd_req_o),
    .resp_valid_i(resp_valid_i), .resp_i(resp_i),
    .wait_valid_i(wait_valid_i), .wait_id_i(wait_id_i),
    .wait_ready_o(wait_ready_o), .wait_data_o(wait_data_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs then change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_resp(input logic [7:0] cl, input logic [3:0] co,
                          input logic [3:0] id, input logic [511:0] d);
    resp_valid_i               = 1'b1;
    resp_i.cmd_id.cluster_id   = cl;
    resp_i.cmd_id.core_id      = co;
    resp_i.cmd_id.local_cmd_id = id;
    resp_i.imm_data            = d;
  endtask

  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_req_i = '0; cmd_ready_i = 1'b1;
    resp_valid_i = 1'b0; resp_i = '0; wait_valid_i = 1'b0; wait_id_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_inflight", 512'(inflight_o), 512'(0));
    chk("rst_cmd_valid", 512'(cmd_valid_o), 512'(0));
    chk("rst_cmd_req", 512'(cmd_req_o), 512'(0));
    chk("rst_err", 512'(err_o), 512'(0));
    chk("rst_issue_ready", 512'(issue_ready_o), 512'(1));

    // Fill all four slots back to back.
    for (int k = 0; k < 4; k++) begin
      issue_valid_i    = 1'b1;
      issue_req_i      = '0;
      issue_req_i.addr = 32'h100 + k;
      issue_req_i.cmd_id = 16'hFFFF;
      #1;
      chk("fill_ready", 512'(issue_ready_o), 512'(1));
      chk("fill_id", 512'(issue_id_o), 512'(k));
      tick();
      chk("fill_cmd_valid", 512'(cmd_valid_o), 512'(1));
      chk("fill_cmd_local", 512'(cmd_req_o.cmd_id.local_cmd_id), 512'(k));
      chk("fill_cmd_cluster", 512'(cmd_req_o.cmd_id.cluster_id), 512'(1));
      chk("fill_cmd_core", 512'(cmd_req_o.cmd_id.core_id), 512'(2));
      chk("fill_cmd_addr", 512'(cmd_req_o.addr), 512'(32'h100 + k));
    end
    #1;
    chk("full_issue_ready", 512'(issue_ready_o), 512'(0));
    chk("full_inflight", 512'(inflight_o), 512'(4));
    issue_valid_i = 1'b0;
    tick();
    chk("drain_cmd_valid", 512'(cmd_valid_o), 512'(0));

    // Complete slot 2, retire it, then reallocate it.
    set_resp(8'd1, 4'd2, 4'd2, 512'hDEAD);
    wait_id_i = 2'd2;
    #1;
    chk("resp_not_yet_visible", 512'(wait_ready_o), 512'(0));
    tick();
    resp_valid_i = 1'b0;
    wait_valid_i = 1'b1;
    #1;
    chk("wait2_ready", 512'(wait_ready_o), 512'(1));
    chk("wait2_data", wait_data_o, 512'hDEAD);
    chk("wait2_err", 512'(err_o), 512'(0));
    tick();
    wait_valid_i = 1'b0;
    #1;
    chk("retire_inflight", 512'(inflight_o), 512'(3));
    issue_valid_i = 1'b1;
    issue_req_i.addr = 32'h200;
    #1;
    chk("realloc_id", 512'(issue_id_o), 512'(2));
    chk("realloc_ready", 512'(issue_ready_o), 512'(1));
    tick();
    issue_valid_i = 1'b0;
    chk("realloc_inflight", 512'(inflight_o), 512'(4));

    // Wait on slot 1 while still issued.
    wait_valid_i = 1'b1;
    wait_id_i    = 2'd1;
    #1;
    chk("wait1_stall_a", 512'(wait_ready_o), 512'(0));
    tick();
    chk("wait1_stall_b", 512'(wait_ready_o), 512'(0));
    set_resp(8'd1, 4'd2, 4'd1, 512'hBEEF);
    #1;
    chk("wait1_stall_c", 512'(wait_ready_o), 512'(0));
    tick();
    resp_valid_i = 1'b0;
    #1;
    chk("wait1_ready", 512'(wait_ready_o), 512'(1));
    chk("wait1_data", wait_data_o, 512'hBEEF);
    tick();
    wait_valid_i = 1'b0;
    chk("wait1_inflight", 512'(inflight_o), 512'(3));

    // Rejected responses: wrong core, then a FREE slot.
    set_resp(8'd1, 4'd3, 4'd0, 512'h1111);
    tick();
    resp_valid_i = 1'b0;
    wait_id_i    = 2'd0;
    #1;
    chk("err_core_pulse", 512'(err_o), 512'(1));
    chk("err_core_inflight", 512'(inflight_o), 512'(3));
    chk("err_core_slot0_issued", 512'(wait_ready_o), 512'(0));
    tick();
    chk("err_core_clear", 512'(err_o), 512'(0));
    set_resp(8'd1, 4'd2, 4'd1, 512'h2222);
    tick();
    resp_valid_i = 1'b0;
    wait_id_i    = 2'd1;
    #1;
    chk("err_free_pulse", 512'(err_o), 512'(1));
    chk("err_free_inflight", 512'(inflight_o), 512'(3));
    chk("free_wait_ready", 512'(wait_ready_o), 512'(1));
    chk("free_wait_data", wait_data_o, 512'(0));

    // Complete and retire slot 3 so two slots are free.
    set_resp(8'd1, 4'd2, 4'd3, 512'h33);
    tick();
    resp_valid_i = 1'b0;
    wait_valid_i = 1'b1;
    wait_id_i    = 2'd3;
    #1;
    chk("wait3_data", wait_data_o, 512'h33);
    tick();
    wait_valid_i = 1'b0;
    chk("wait3_inflight", 512'(inflight_o), 512'(2));

    // Backpressure on the output register.
    cmd_ready_i      = 1'b0;
    issue_valid_i    = 1'b1;
    issue_req_i.addr = 32'h55;
    #1;
    chk("bp_first_id", 512'(issue_id_o), 512'(1));
    tick();
    issue_req_i.addr = 32'h66;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_valid", 512'(cmd_valid_o), 512'(1));
      chk("bp_addr", 512'(cmd_req_o.addr), 512'(32'h55));
      chk("bp_local", 512'(cmd_req_o.cmd_id.local_cmd_id), 512'(1));
      chk("bp_issue_ready", 512'(issue_ready_o), 512'(0));
      tick();
    end
    cmd_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 512'(issue_ready_o), 512'(1));
    chk("bp_release_id", 512'(issue_id_o), 512'(3));
    tick();
    issue_valid_i = 1'b0;
    chk("bp_next_addr", 512'(cmd_req_o.addr), 512'(32'h66));
    chk("bp_next_local", 512'(cmd_req_o.cmd_id.local_cmd_id), 512'(3));
    chk("bp_inflight", 512'(inflight_o), 512'(4));

    // Reset mid-operation.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_inflight", 512'(inflight_o), 512'(0));
    chk("mid_rst_cmd_valid", 512'(cmd_valid_o), 512'(0));
    issue_valid_i = 1'b1;
    #1;
    chk("mid_rst_issue_id", 512'(issue_id_o), 512'(0));
    tick();
    issue_valid_i = 1'b0;
    chk("mid_rst_cmd_local", 512'(cmd_req_o.cmd_id.local_cmd_id), 512'(0));
    chk("mid_rst_inflight_after", 512'(inflight_o), 512'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
